// File: rtl/serial_gpio_pkg.sv
// Shared types and constants for the serial GPIO expander.
package serial_gpio_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_DATA,
    SEND
  } state_t;

  localparam int         CMD_W_BIT    = 7;
  localparam int         IDX_W        = 7;
  localparam logic [7:0] BAD_IDX_BYTE = 8'hFF;

endpackage

// File: rtl/gpio_in_sync.sv
// Two-flop synchronizer bank for asynchronous GPIO input pins.
module gpio_in_sync #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/serial_gpio_bank.sv
// Byte-command GPIO expander: addressed writes to output ports, synchronized
// input read-back through the transmitter, data-byte timeout and error pulse.
module serial_gpio_bank
  import serial_gpio_pkg::*;
#(
  parameter int NUM_PORTS   = 4,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rx_valid,
  input  logic [7:0]             rx_data,
  input  logic                   tx_busy,
  output logic                   tx_start,
  output logic [7:0]             tx_data,
  input  logic [NUM_PORTS*8-1:0] gp_in,
  output logic [NUM_PORTS*8-1:0] gp_out,
  output logic                   cmd_err
);

  localparam int W     = NUM_PORTS * 8;
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [W-1:0] gp_sync;

  gpio_in_sync #(.WIDTH(W)) u_in_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (gp_in),
    .q     (gp_sync)
  );

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             err_q, err_d;
  logic [W-1:0]     gp_out_q, gp_out_d;
  logic             wr_en;
  logic             timeout;
  logic             tx_start_c;

  logic [IDX_W-1:0] rx_idx;
  logic             rx_in_range;
  logic             idx_in_range;
  logic [W-1:0]     rd_masked;
  logic [7:0][NUM_PORTS-1:0] rd_col;
  logic [7:0]       rd_or;
  logic [7:0]       rd_byte;

  assign rx_idx       = rx_data[IDX_W-1:0];
  assign rx_in_range  = int'(rx_idx) < NUM_PORTS;
  assign idx_in_range = int'(idx_q) < NUM_PORTS;

  // One-hot masked read mux, OR-reduced per bit column across ports.
  genvar gi, gj;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      assign rd_masked[gi*8 +: 8] = (rx_idx == IDX_W'(gi)) ? gp_sync[gi*8 +: 8] : 8'h00;
      assign gp_out_d[gi*8 +: 8]  = (wr_en && (idx_q == IDX_W'(gi))) ? rx_data
                                                                      : gp_out_q[gi*8 +: 8];
    end
    for (gi = 0; gi < 8; gi++) begin : g_bit
      for (gj = 0; gj < NUM_PORTS; gj++) begin : g_col
        assign rd_col[gi][gj] = rd_masked[gj*8 + gi];
      end
      assign rd_or[gi] = |rd_col[gi];
    end
  endgenerate

  assign rd_byte = rx_in_range ? rd_or : BAD_IDX_BYTE;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = '0;
    tx_data_d  = tx_data_q;
    err_d      = 1'b0;
    wr_en      = 1'b0;
    timeout    = 1'b0;
    tx_start_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rx_valid) begin
          if (rx_data[CMD_W_BIT]) begin
            idx_d   = rx_idx;
            state_d = WAIT_DATA;
          end else begin
            tx_data_d = rd_byte;
            err_d     = !rx_in_range;
            state_d   = SEND;
          end
        end
      end
      WAIT_DATA: begin
        cnt_d = (cnt_q == CNT_LAST) ? cnt_q : cnt_q + CNT_W'(1);
        if (rx_valid) begin
          wr_en   = idx_in_range;
          err_d   = !idx_in_range;
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          timeout = 1'b1;
          state_d = IDLE;
        end
      end
      SEND: begin
        // Byte arriving while a read is still queued is dropped.
        err_d = rx_valid;
        if (!tx_busy) begin
          tx_start_c = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      tx_data_q <= 8'h00;
      err_q     <= 1'b0;
      gp_out_q  <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      tx_data_q <= tx_data_d;
      err_q     <= err_d;
      gp_out_q  <= gp_out_d;
    end
  end

  assign tx_start = tx_start_c;
  assign tx_data  = tx_data_q;
  assign gp_out   = gp_out_q;
  assign cmd_err  = err_q | timeout;

endmodule

// File: tb/tb_serial_gpio_bank.sv
// Self-checking bench: directed protocol scenarios plus randomized traffic
// compared every cycle against a transaction-level model.
module tb_serial_gpio_bank;

  localparam int N = 4;
  localparam int T = 16;
  localparam int W = N * 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         rx_valid = 1'b0;
  logic [7:0]   rx_data = 8'h00;
  logic         tx_busy = 1'b0;
  logic [W-1:0] gp_in = '0;
  logic         tx_start;
  logic [7:0]   tx_data;
  logic [W-1:0] gp_out;
  logic         cmd_err;

  always #5 clk = ~clk;

  serial_gpio_bank #(.NUM_PORTS(N), .TIMEOUT_CYC(T)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .tx_busy  (tx_busy),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .gp_in    (gp_in),
    .gp_out   (gp_out),
    .cmd_err  (cmd_err)
  );

  int checks = 0;
  int failures = 0;
  int start_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;

  // Transaction-level model state
  bit         wr_pend = 0;
  bit         rd_pend = 0;
  bit         err_next = 0;
  int         wr_port = 0;
  int         wr_cyc = 0;
  logic [7:0] m_txdata = 8'h00;
  logic [7:0] gp_m [N];
  logic [7:0] h1 [N];
  logic [7:0] h2 [N];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=0x%0h required=0x%0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [7:0] byte_of(input logic [W-1:0] v, input int k);
    logic [W-1:0] t;
    t = v >> (8 * k);
    return t[7:0];
  endfunction

  function automatic logic [W-1:0] pack_gp();
    logic [W-1:0] acc;
    acc = '0;
    for (int k = 0; k < N; k++) acc = acc | (W'(gp_m[k]) << (8 * k));
    return acc;
  endfunction

  initial begin
    for (int k = 0; k < N; k++) begin
      gp_m[k] = 8'h00;
      h1[k] = 8'h00;
      h2[k] = 8'h00;
    end
  end

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    bit to;
    bit exp_start;
    bit exp_err;
    bit nxt_err;
    int p;
    cyc++;
    if (tx_start === 1'b1) start_cnt++;
    if (cmd_err === 1'b1) err_cnt++;
    if (!rst_n) begin
      wr_pend = 0;
      rd_pend = 0;
      err_next = 0;
      m_txdata = 8'h00;
      for (int k = 0; k < N; k++) begin
        gp_m[k] = 8'h00;
        h1[k] = 8'h00;
        h2[k] = 8'h00;
      end
      check("rst_gp_out", gp_out, '0);
      check("rst_tx_start", 32'(tx_start), 32'd0);
      check("rst_cmd_err", 32'(cmd_err), 32'd0);
      check("rst_tx_data", 32'(tx_data), 32'd0);
    end else begin
      to = wr_pend && !rx_valid && ((cyc - wr_cyc) == T);
      exp_start = rd_pend && !tx_busy;
      exp_err = err_next || to;
      check("m_gp_out", gp_out, pack_gp());
      check("m_tx_start", 32'(tx_start), 32'(exp_start));
      check("m_cmd_err", 32'(cmd_err), 32'(exp_err));
      check("m_tx_data", 32'(tx_data), 32'(m_txdata));
      nxt_err = 0;
      if (rd_pend) begin
        if (rx_valid) nxt_err = 1;
        if (!tx_busy) rd_pend = 0;
      end else if (wr_pend) begin
        if (rx_valid) begin
          if (wr_port < N) gp_m[wr_port] = rx_data;
          else nxt_err = 1;
          wr_pend = 0;
        end else if (to) begin
          wr_pend = 0;
        end
      end else if (rx_valid) begin
        p = int'(rx_data[6:0]);
        if (rx_data[7]) begin
          wr_pend = 1;
          wr_port = p;
          wr_cyc = cyc;
        end else begin
          rd_pend = 1;
          m_txdata = (p < N) ? h2[p] : 8'hFF;
          nxt_err = (p >= N);
        end
      end
      err_next = nxt_err;
      for (int k = 0; k < N; k++) begin
        h2[k] = h1[k];
        h1[k] = byte_of(gp_in, k);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data = b;
    tick();
    rx_valid = 1'b0;
  endtask

  initial begin
    int s0;
    int e0;
    repeat (3) tick();
    check("reset_gp_out", gp_out, 32'h0000_0000);
    check("reset_tx_data", 32'(tx_data), 32'h00);
    rst_n = 1'b1;
    repeat (3) tick();

    // Write 0x5A to port 2
    send(8'h82);
    send(8'h5A);
    check("write_port2", gp_out, 32'h005A_0000);

    // Read port 1 with an idle transmitter
    gp_in = 32'h0000_C300;
    repeat (3) tick();
    e0 = err_cnt;
    s0 = start_cnt;
    send(8'h01);
    check("read_start", 32'(tx_start), 32'd1);
    check("read_data", 32'(tx_data), 32'hC3);
    tick();
    check("read_start_drop", 32'(tx_start), 32'd0);
    tick();
    check("read_no_err", 32'(err_cnt - e0), 32'd0);
    check("read_one_pulse", 32'(start_cnt - s0), 32'd1);

    // Read port 0 behind a busy transmitter
    gp_in = 32'h00A5_C33C;
    tx_busy = 1'b1;
    repeat (3) tick();
    s0 = start_cnt;
    send(8'h00);
    repeat (48) tick();
    check("busy_hold", 32'(tx_start), 32'd0);
    check("busy_no_pulse", 32'(start_cnt - s0), 32'd0);
    tx_busy = 1'b0;
    #1;
    check("busy_release_start", 32'(tx_start), 32'd1);
    check("busy_release_data", 32'(tx_data), 32'h3C);
    tick();
    check("busy_start_drop", 32'(tx_start), 32'd0);
    repeat (3) tick();
    check("busy_one_pulse", 32'(start_cnt - s0), 32'd1);

    // Out-of-range read
    e0 = err_cnt;
    send(8'h05);
    check("oor_rd_start", 32'(tx_start), 32'd1);
    check("oor_rd_data", 32'(tx_data), 32'hFF);
    check("oor_rd_err", 32'(cmd_err), 32'd1);
    tick();
    check("oor_rd_err_once", 32'(err_cnt - e0), 32'd1);

    // Out-of-range write
    e0 = err_cnt;
    send(8'h87);
    send(8'h11);
    tick();
    check("oor_wr_gp_out", gp_out, 32'h005A_0000);
    check("oor_wr_err_once", 32'(err_cnt - e0), 32'd1);

    // Timeout after a lone write command
    e0 = err_cnt;
    send(8'h80);
    repeat (14) tick();
    check("timeout_early", 32'(cmd_err), 32'd0);
    tick();
    check("timeout_fire", 32'(cmd_err), 32'd1);
    tick();
    check("timeout_drop", 32'(cmd_err), 32'd0);
    check("timeout_once", 32'(err_cnt - e0), 32'd1);
    send(8'h03);
    check("after_to_read_start", 32'(tx_start), 32'd1);
    check("after_to_read_data", 32'(tx_data), 32'h00);
    check("after_to_gp_out", gp_out, 32'h005A_0000);
    tick();

    // Reset between a write command and its data byte
    send(8'h81);
    rst_n = 1'b0;
    #1;
    check("async_rst_gp_out", gp_out, 32'h0000_0000);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    s0 = start_cnt;
    send(8'h02);
    check("post_rst_read_start", 32'(tx_start), 32'd1);
    check("post_rst_read_data", 32'(tx_data), 32'hA5);
    check("post_rst_gp_out", gp_out, 32'h0000_0000);
    tick();

    // Randomized traffic, including overruns and long gaps for timeouts
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 3) == 0) gp_in = W'($urandom());
      tx_busy = ($urandom_range(0, 2) == 0);
      rx_valid = ($urandom_range(0, 2) == 0) && (((i / 40) % 5) != 4);
      rx_data = 8'($urandom());
      if ($urandom_range(0, 3) != 0) rx_data[6:0] = 7'($urandom_range(0, 5));
      tick();
    end
    rx_valid = 1'b0;
    tx_busy = 1'b0;
    repeat (25) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
